matrix_buffer: RTL and testbench

Double-buffered, parametrised DIM×DIM matrix store for the TPU datapath. It replaces the fixed 4×4 group memory. A producer streams rows into the fill bank while the systolic array reads the other (drain) bank by row, or by column for transposed operands. Bank hand-off is by explicit full/release handshake, with a sticky error flag for protocol violations.

---
 rtl/tpu_pkg.sv | 13 +
 rtl/matrix_bank.sv | 49 ++++
 rtl/matrix_buffer.sv | 135 +++++++++++++
 tb/tb_matrix_buffer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU matrix datapath.
// Default element width/dimension and the read-mode encoding.
package tpu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DIM   = 4;

    typedef enum logic {
        RD_ROW = 1'b0,
        RD_COL = 1'b1
    } rd_mode_t;

endpackage

// File: rtl/matrix_bank.sv
// One DIM x DIM element store: row write, row or column read.
// Column mux only exists with MATRIX_BUFFER_TRANSPOSE_EN defined.
import tpu_pkg::*;

module matrix_bank #(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DIM   = DEF_DIM,
    localparam int AW    = $clog2(DIM)
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [DIM*WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]        raddr_i,
    input  rd_mode_t             mode_i,
    output logic [DIM*WIDTH-1:0] rdata_o
);

    logic [DIM*WIDTH-1:0] mem_q [DIM];

    // Row store; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    // Row read, or gather column raddr_i across all rows
    always_comb begin
        rdata_o = mem_q[raddr_i];
        if (mode_i == RD_COL) begin
            for (int i = 0; i < DIM; i++) begin
                rdata_o[i*WIDTH +: WIDTH] =
                    mem_q[i][int'(raddr_i)*WIDTH +: WIDTH];
            end
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode_i;

    // Row read only
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end
`endif

endmodule

// File: rtl/matrix_buffer.sv
// Double-buffered DIM x DIM matrix store with full/release hand-off.
// Define MATRIX_BUFFER_TRANSPOSE_EN to enable column (transpose) reads.
import tpu_pkg::*;

module matrix_buffer #(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DIM   = DEF_DIM,
    localparam int AW    = $clog2(DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [DIM*WIDTH-1:0] wr_data,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    input  logic                 rd_col,
    output logic                 rd_valid,
    output logic [DIM*WIDTH-1:0] rd_data,
    input  logic                 rd_release,
    output logic                 drain_ready,
    output logic                 err
);

    logic                 fp_q, fp_d;
    logic                 dp_q, dp_d;
    logic [1:0]           full_q, full_d;
    logic [AW-1:0]        wcnt_q, wcnt_d;
    logic                 err_q, err_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [DIM*WIDTH-1:0] rd_data_q, rd_data_d;

    logic                 wr_acc;
    logic                 rd_acc;
    logic                 rel_acc;
    logic                 wr_last;
    rd_mode_t             rd_mode;
    logic [DIM*WIDTH-1:0] bank_rdata [2];

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
    assign rd_mode = rd_col ? RD_COL : RD_ROW;
`else
    logic unused_rd_col;
    assign unused_rd_col = rd_col;
    assign rd_mode = RD_ROW;
`endif

    assign wr_ready    = !full_q[fp_q];
    assign drain_ready = full_q[dp_q];
    assign wr_acc      = wr_valid && wr_ready;
    assign rd_acc      = rd_req && drain_ready;
    assign rel_acc     = rd_release && drain_ready;
    assign wr_last     = (wcnt_q == AW'(DIM - 1));

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            matrix_bank #(
                .WIDTH (WIDTH),
                .DIM   (DIM)
            ) u_bank (
                .clk_i   (clk),
                .we_i    (wr_acc && (fp_q == 1'(b))),
                .waddr_i (wcnt_q),
                .wdata_i (wr_data),
                .raddr_i (rd_addr),
                .mode_i  (rd_mode),
                .rdata_o (bank_rdata[b])
            );
        end
    endgenerate

    // Next state: fill progress, bank hand-off, read result, error latch
    always_comb begin
        fp_d       = fp_q;
        dp_d       = dp_q;
        full_d     = full_q;
        wcnt_d     = wcnt_q;
        err_d      = err_q;
        rd_valid_d = rd_acc;
        rd_data_d  = '0;

        if (rd_acc) begin
            rd_data_d = bank_rdata[dp_q];
        end

        // Release and fill completion never target the same bank
        if (rel_acc) begin
            full_d[dp_q] = 1'b0;
            dp_d         = ~dp_q;
        end

        if (wr_acc) begin
            if (wr_last) begin
                full_d[fp_q] = 1'b1;
                fp_d         = ~fp_q;
                wcnt_d       = '0;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end

        if ((wr_valid && !wr_ready) ||
            (rd_req && !drain_ready) ||
            (rd_release && !drain_ready)) begin
            err_d = 1'b1;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fp_q       <= 1'b0;
            dp_q       <= 1'b0;
            full_q     <= '0;
            wcnt_q     <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            fp_q       <= fp_d;
            dp_q       <= dp_d;
            full_q     <= full_d;
            wcnt_q     <= wcnt_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_matrix_buffer.sv
// Self-checking bench for matrix_buffer (WIDTH=8, DIM=4).
// Reference model: FIFO of completed matrices plus one partial matrix.
module tb_matrix_buffer;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int RW = W * D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [RW-1:0] wr_data = '0;
    logic          rd_req = 1'b0;
    logic [1:0]    rd_addr = '0;
    logic          rd_col = 1'b0;
    logic          rd_valid;
    logic [RW-1:0] rd_data;
    logic          rd_release = 1'b0;
    logic          drain_ready;
    logic          err;

    matrix_buffer #(.WIDTH(W), .DIM(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_col      (rd_col),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_release  (rd_release),
        .drain_ready (drain_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: queue of complete matrices (row r at [r*RW +: RW])
    logic [D*RW-1:0] full_mats[$];
    logic [D*RW-1:0] partial;
    int              prows;
    logic            m_err;
    logic            m_valid;
    logic [RW-1:0]   m_data;

    task automatic chk(input string tag, input logic [RW-1:0] obs,
                       input logic [RW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] mread(input logic [D*RW-1:0] m,
                                            input int a, input bit col);
        logic [RW-1:0] r;
        r = m[a*RW +: RW];
`ifdef MATRIX_BUFFER_TRANSPOSE_EN
        if (col) begin
            for (int i = 0; i < D; i++) begin
                r[i*W +: W] = m[i*RW + a*W +: W];
            end
        end
`else
        if (col) r = m[a*RW +: RW];
`endif
        return r;
    endfunction

    task automatic model_reset();
        full_mats.delete();
        partial = '0;
        prows   = 0;
        m_err   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".rd_valid"}, RW'(rd_valid), RW'(m_valid));
        chk({tag, ".rd_data"}, rd_data, m_data);
        chk({tag, ".err"}, RW'(err), RW'(m_err));
        chk({tag, ".wr_ready"}, RW'(wr_ready), RW'(full_mats.size() < 2));
        chk({tag, ".drain_ready"}, RW'(drain_ready),
            RW'(full_mats.size() > 0));
    endtask

    // One clock cycle of stimulus, model update, then output check
    task automatic step(input string tag, input logic wv,
                        input logic [RW-1:0] wd, input logic rq,
                        input int ra, input logic rc, input logic rel);
        int  sz;
        wr_valid   = wv;
        wr_data    = wd;
        rd_req     = rq;
        rd_addr    = 2'(ra);
        rd_col     = rc;
        rd_release = rel;
        sz = full_mats.size();
        m_valid = rq && (sz > 0);
        m_data  = m_valid ? mread(full_mats[0], ra, rc) : '0;
        if ((wv && sz == 2) || ((rq || rel) && sz == 0)) m_err = 1'b1;
        if (rel && sz > 0) void'(full_mats.pop_front());
        if (wv && sz < 2) begin
            partial[prows*RW +: RW] = wd;
            prows++;
            if (prows == D) begin
                full_mats.push_back(partial);
                prows = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outs(tag);
    endtask

    task automatic wr(input string tag, input logic [RW-1:0] wd);
        step(tag, 1'b1, wd, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic rd(input string tag, input int a, input logic c);
        step(tag, 1'b0, '0, 1'b1, a, c, 1'b0);
    endtask

    task automatic rel(input string tag);
        step(tag, 1'b0, '0, 1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        wr_valid = 0; rd_req = 0; rd_release = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [RW-1:0] col_exp;

    initial begin
        model_reset();
        #1;
        check_outs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a fill
        wr("pre0", 32'hAAAA0000);
        wr("pre1", 32'hAAAA0001);
        do_reset("rst_midfill");

        // Fill bank 0
        wr("fill0", 32'h03020100);
        wr("fill1", 32'h07060504);
        wr("fill2", 32'h0B0A0908);
        wr("fill3", 32'h0F0E0D0C);
        chk("drain_up", RW'(drain_ready), RW'(1));

        rd("row2", 2, 1'b0);
        chk("row2_const", rd_data, 32'h0B0A0908);

`ifdef MATRIX_BUFFER_TRANSPOSE_EN
        col_exp = 32'h0D090501;
`else
        col_exp = 32'h07060504;
`endif
        rd("col1", 1, 1'b1);
        chk("col1_const", rd_data, col_exp);
        idle("idle_after_rd");

        // Bank 1: three rows, then completion + read + release together
        wr("b1r0", 32'h13121110);
        wr("b1r1", 32'h17161514);
        wr("b1r2", 32'h1B1A1918);
        step("simul", 1'b1, 32'h1F1E1D1C, 1'b1, 0, 1'b0, 1'b1);
        chk("simul_const", rd_data, 32'h03020100);
        rd("b1_row3", 3, 1'b0);
        chk("b1_row3_const", rd_data, 32'h1F1E1D1C);

        // Fill bank 0 again while bank 1 is held: both full
        for (int r = 0; r < D; r++) begin
            wr("fill_both", 32'h20202020 + 32'(r));
        end
        chk("wr_ready_low", RW'(wr_ready), RW'(0));
        wr("dropped", 32'hDEADBEEF);
        chk("drop_err", RW'(err), RW'(1));
        rel("rel_b1");
        chk("wr_ready_back", RW'(wr_ready), RW'(1));
        wr("after_rel", 32'h30303030);
        rd("b0_row0", 0, 1'b0);
        chk("b0_row0_const", rd_data, 32'h20202020);

        // Protocol errors on an empty drain bank
        do_reset("rst2");
        rd("rd_empty", 1, 1'b0);
        chk("rd_empty_err", RW'(err), RW'(1));
        rel("rel_empty");
        idle("idle_err");

        // Randomised traffic against the model
        do_reset("rst3");
        for (int k = 0; k < 400; k++) begin
            step("rand", ($urandom_range(0, 99) < 60), $urandom,
                 ($urandom_range(0, 99) < 35), $urandom_range(0, 3),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 12));
        end
        idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
